// File: rtl/tc140_pkg.sv
`default_nettype none
// ============================================================================
//  Module : tc140_pkg
//  Shared loader state codes and program-memory geometry.
//  Rev    : 1.0
// ============================================================================
package tc140_pkg;

    localparam int MEM_AW    = 8;
    localparam int MEM_DW    = 16;
    localparam int MEM_DEPTH = 256;

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t ST_IDLE  = 3'd0;
    localparam loader_state_t ST_HDR   = 3'd1;
    localparam loader_state_t ST_HI    = 3'd2;
    localparam loader_state_t ST_LO    = 3'd3;
    localparam loader_state_t ST_WRITE = 3'd4;
    localparam loader_state_t ST_HOLD  = 3'd5;
    localparam loader_state_t ST_CHK   = 3'd6;
    localparam loader_state_t ST_FIN   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/loader_cksum.sv
`default_nettype none
// ============================================================================
//  Module : loader_cksum
//  Modulo-256 running sum of header and data bytes of a program load.
//  Rev    : 1.0
// ============================================================================
module loader_cksum
    import tc140_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] add_byte,
    output logic [7:0] sum
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = 8'h00;
        end else if (add_en) begin
            sum_d = sum_q + add_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module : prog_loader
//  Byte-stream program loader for a 256x16 RAM; holds the CPU in reset while
//  loading. Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
//  Rev    : 1.0
// ============================================================================
module prog_loader
    import tc140_pkg::*;
#(
    parameter logic [MEM_AW-1:0] START_ADDR = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [MEM_AW-1:0] mem_address,
    output logic [MEM_DW-1:0] mem_data,
    output logic              mem_write,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [7:0]        hi_q, hi_d;
    logic [MEM_AW-1:0] mem_address_q, mem_address_d;
    logic [MEM_DW-1:0] mem_data_q, mem_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              xfer;

    assign byte_ready = (state_q == ST_HDR) || (state_q == ST_HI) ||
                        (state_q == ST_LO)  || (state_q == ST_CHK);
    assign xfer       = byte_valid && byte_ready;

`ifdef LOADER_CHECKSUM_EN
    logic       error_q, error_d;
    logic [7:0] cksum_sum;
    logic       cksum_add;

    assign cksum_add = xfer && ((state_q == ST_HDR) || (state_q == ST_HI) ||
                                (state_q == ST_LO));

    loader_cksum u_cksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    ((state_q == ST_IDLE) && start),
        .add_en   (cksum_add),
        .add_byte (byte_data),
        .sum      (cksum_sum)
    );
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        hi_d          = hi_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        cpu_reset_d   = cpu_reset_q;
`ifdef LOADER_CHECKSUM_EN
        error_d       = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_HDR;
                    cpu_reset_d = 1'b1;
                    addr_d      = START_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    error_d     = 1'b0;
`endif
                end
            end
            ST_HDR: begin
                // Header N means N+1 words; remaining counts words after the current one.
                if (xfer) begin
                    remaining_d = byte_data;
                    state_d     = ST_HI;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    mem_data_d    = {hi_q, byte_data};
                    mem_address_d = addr_q;
                    state_d       = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                addr_d = addr_q + 8'd1;
                if (remaining_q != 8'd0) begin
                    remaining_d = remaining_q - 8'd1;
                    state_d     = ST_HI;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_FIN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                // A bad checksum leaves the CPU held in reset.
                if (xfer) begin
                    if (byte_data == cksum_sum) begin
                        state_d = ST_FIN;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            ST_FIN: begin
                cpu_reset_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= 8'h00;
            remaining_q   <= 8'h00;
            hi_q          <= 8'h00;
            mem_address_q <= 8'h00;
            mem_data_q    <= 16'h0000;
            cpu_reset_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            hi_q          <= hi_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            cpu_reset_q   <= cpu_reset_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_write   = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    // cpu_reset drops in the FIN cycle itself, alongside the done pulse.
    assign cpu_reset   = cpu_reset_q && !done;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized scoreboard bench for prog_loader (START_ADDR=FE exercises address wrap).
module tb_prog_loader;

    localparam logic [7:0] START = 8'hFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic [7:0]  mem_address;
    logic [15:0] mem_data;
    logic        mem_write;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_seen = 0;

    logic [23:0] exp_q [$];
    logic [15:0] words_q [$];

    logic        prev_write = 1'b0;
    logic        prev_done  = 1'b0;
    logic [7:0]  prev_addr  = 8'h00;
    logic [15:0] prev_data  = 16'h0000;
    logic [23:0] mon_e;

    always #5 clk = ~clk;

    prog_loader #(.START_ADDR(START)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_write   (mem_write),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Monitor: pops expected writes and checks write/hold/done protocol.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_write = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (mem_write) begin
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", mem_address, mon_e[23:16]);
                    check("write_data", mem_data, mon_e[15:0]);
                end
                check("ready_in_write", byte_ready, 0);
                check("cpu_reset_in_write", cpu_reset, 1);
            end
            if (prev_write) begin
                check("write_one_cycle", mem_write, 0);
                check("ready_in_hold", byte_ready, 0);
                check("hold_addr_stable", mem_address, prev_addr);
                check("hold_data_stable", mem_data, prev_data);
            end
            if (done) begin
                done_seen++;
                check("cpu_reset_low_at_done", cpu_reset, 0);
                check("done_one_cycle", prev_done, 0);
            end
            prev_write = mem_write;
            prev_done  = done;
            prev_addr  = mem_address;
            prev_data  = mem_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit pulse_start);
        int gap;
        int n;
        bit acc;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        acc = 1'b0;
        n   = 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        if (pulse_start) start = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        if (!acc) begin
            total_cnt++;
            $display("FAIL byte_accept_timeout: got ready=0 required ready=1 for byte %0h", b);
        end
    endtask

    task automatic pulse_start_idle();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Loads words_q (nwords entries); model expects START+i addresses and a summed checksum.
    task automatic do_load(input int max_gap, input bit glitch, input bit bad_ck);
        int          nwords;
        int          d0;
        int          n;
        logic [7:0]  hdr;
        logic [7:0]  sum;
        logic [7:0]  a;
        logic [15:0] w;
        bit          expect_bad;
        nwords = words_q.size();
        hdr    = 8'(nwords - 1);
        d0     = done_seen;
`ifdef LOADER_CHECKSUM_EN
        expect_bad = bad_ck;
`else
        expect_bad = 1'b0;
`endif
        pulse_start_idle();
        check("busy_after_start", busy, 1);
        check("cpu_reset_after_start", cpu_reset, 1);
        check("error_cleared_on_start", error, 0);
        sum = hdr;
        send_byte(hdr, max_gap, 1'b0);
        for (int i = 0; i < nwords; i++) begin
            w = words_q.pop_front();
            a = START + 8'(i);
            exp_q.push_back({a, w});
            sum = sum + w[15:8] + w[7:0];
            send_byte(w[15:8], max_gap, 1'b0);
            send_byte(w[7:0], max_gap, glitch && (i == 0));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_ck ? sum + 8'd1 : sum, max_gap, 1'b0);
`endif
        byte_valid = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("load_finishes", busy, 0);
        check("all_writes_seen", exp_q.size(), 0);
        check("done_count", done_seen - d0, expect_bad ? 0 : 1);
        check("cpu_reset_after_load", cpu_reset, expect_bad ? 1 : 0);
        check("error_after_load", error, expect_bad ? 1 : 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_byte_ready"}, byte_ready, 0);
        check({tag, "_mem_address"}, mem_address, 0);
        check({tag, "_mem_data"}, mem_data, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_cpu_reset"}, cpu_reset, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    initial begin
        logic [15:0] w;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single word 1234.
        words_q.push_back(16'h1234);
        do_load(0, 1'b0, 1'b0);

        // Three words across the FF->00 wrap.
        for (int i = 0; i < 3; i++) words_q.push_back(16'($urandom));
        do_load(2, 1'b0, 1'b0);

        // Randomized loads with random stalls.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < int'($urandom_range(6, 1)); i++) words_q.push_back(16'($urandom));
            do_load(3, 1'b0, 1'b0);
        end

        // Start pulsed while in LO must be ignored.
        for (int i = 0; i < 3; i++) words_q.push_back(16'($urandom));
        do_load(0, 1'b1, 1'b0);

        // Reset in the middle of a 4-word load, after the second HI byte.
        pulse_start_idle();
        send_byte(8'h03, 0, 1'b0);
        w = 16'($urandom);
        exp_q.push_back({START, w});
        send_byte(w[15:8], 0, 1'b0);
        send_byte(w[7:0], 0, 1'b0);
        w = 16'($urandom);
        send_byte(w[15:8], 0, 1'b0);
        check("first_word_written_before_reset", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        repeat (3) begin
            @(negedge clk);
            check("no_write_in_reset", mem_write, 0);
        end
        #2 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_after_reset", busy, 0);
            check("no_write_after_reset", mem_write, 0);
        end
        byte_valid = 1'b0;
        for (int i = 0; i < 2; i++) words_q.push_back(16'($urandom));
        do_load(1, 1'b0, 1'b0);

        // Maximum load: 256 words, byte_valid held high throughout.
        for (int i = 0; i < 256; i++) words_q.push_back(16'($urandom));
        do_load(0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        words_q.push_back(16'h0102);
        words_q.push_back(16'h0304);
        do_load(0, 1'b0, 1'b0);
        words_q.push_back(16'h0102);
        words_q.push_back(16'h0304);
        do_load(0, 1'b0, 1'b1);
        words_q.push_back(16'($urandom));
        do_load(1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
